wash_sequencer: RTL
===================

# wash_sequencer

Program sequencer for the washer's actuator datapath: it steps the inlet valve, drum motor, drain valve and spin outputs through the enabled wash, rinse and dry stages. Each phase is timed by a shared 1 Hz tick. The block sits between the button/mode front end and the LED/actuator view, and supplies a seconds-remaining count and phase code for the displays. It also handles door-open pause/resume and the end-of-program beep.

## Interface
- `FILL_S`, 2: seconds per fill phase
- `WASH_S`, 9: seconds of wash agitation
- `RINSE_S`, 6: seconds of agitation per rinse
- `DRAIN_S`, 2: seconds per drain phase
- `SPIN_S`, 3: seconds of spin-dry
- `BEEP_S`, 3: seconds the done beep stays on
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `tick` in 1: one-`clk` strobe, once per second
- `start` in 1: one-`clk` start pulse (already synchronised)
- `door_open` in 1: level, 1 = door open
- `mode` in 3: stage enables; [2] wash, [1] rinse, [0] dry
- `rinse_cnt` in 2: rinse repetitions, 0 treated as 1
- `phase` out 3: current state code (package enum)
- `remain` out 8: seconds left in the whole program
- `in_water`, `motor`, `out_water`, `spin` out 1 each: actuator enables
- `busy` out 1: program running or paused
- `done` out 1: program completed
- `beep` out 1: done beeper

## Operation
- States:
  - IDLE
  - FILL
  - WASH
  - RINSE
  - DRAIN
  - SPIN
  - PAUSE
  - DONE
- Stage sequence:
  - Wash stage: FILL → WASH → DRAIN.
  - Rinse stage: (FILL → RINSE → DRAIN), repeated rinse_cnt times.
  - Dry stage: SPIN.
  - Disabled stages are skipped.
- Starting a program:
  - In IDLE or DONE, `start` with `mode != 0` and `!door_open` latches `mode` and `rinse_cnt`.
  - It then loads `remain` with the sum of all enabled phase durations and enters the first enabled phase.
  - Otherwise `start` is ignored.
  - `start` is ignored while `busy`.
- Phase timer:
  - Loaded with the phase duration on phase entry.
  - Each `tick` decrements both the phase timer and `remain`; `remain` saturates at 0.
  - On the tick where the phase timer goes 1→0, the block advances to the next phase.
  - After the last phase it enters DONE.
- Actuator outputs:
  - FILL: `in_water`.
  - WASH, RINSE: `motor`.
  - DRAIN: `out_water`.
  - SPIN: `out_water` and `spin`.
  - All other states: all actuator outputs 0.
- Pause:
  - `door_open` in any running phase → PAUSE. The phase and timer are saved and all actuator outputs go to 0.
  - On `!door_open`, the block returns to the saved phase with its residual count.
  - Ticks in PAUSE are discarded.
- DONE:
  - `done` = 1 and `beep` = 1 for `BEEP_S` ticks, then `beep` = 0.
  - `done` holds until the next accepted `start` or `reset`.
- Simultaneous events:
  - `tick` and `door_open` in the same cycle: pause wins and the tick is discarded.
  - `start` and `tick` in IDLE: start is accepted and the tick is ignored.
  - `tick` and the door closing on the same cycle in PAUSE: the tick is discarded.
- Width rule: the elaboration-time check `FILL_S+WASH_S+3*(FILL_S+RINSE_S+DRAIN_S)+2*DRAIN_S+SPIN_S <= 255` must hold, otherwise elaboration fails.

## Timing
- Reset: all outputs 0, `phase` = IDLE, `remain` = 0. Reset is asynchronous and aborts any running program immediately.
- Outputs are decoded from registered state only; there is no combinational path from the inputs.
- Latencies:
  - `start` sampled at edge n → `busy`, `phase` and the first actuator output are valid after edge n.
  - A terminal tick at edge n → the next phase's outputs are valid after edge n.
  - `door_open` sampled at edge n → actuator outputs are 0 after edge n.
- A full default program (wash + 1 rinse + dry) takes 26 ticks from start to DONE.

## Configuration
- `WASHER_BEEP_EN` defined: beep counter present; `beep` behaves as described.
- `WASHER_BEEP_EN` undefined: the beep logic is removed, `beep` is tied to 0, and `done` behaviour is unchanged.

## Structure
- `washer_pkg` holds:
  - the phase enum (3-bit);
  - default duration constants;
  - the `mode` bit-position constants.
- One sub-module, `sec_timer`: a loadable 8-bit down-counter with a tick enable, a hold input and a zero flag. It is used for the phase timer and the beep timer.

## Test plan
- `mode`=3'b111, `rinse_cnt`=1, `start` → `remain`=26. Phase order FILL(2) WASH(9) DRAIN(2) FILL(2) RINSE(6) DRAIN(2) SPIN(3), then DONE. `beep` lasts 3 ticks and `done` stays at 1.
- `mode`=3'b010, `rinse_cnt`=0 → exactly one rinse group, `remain`=10, no WASH or SPIN phase.
- During WASH with 5 s left, `door_open` for 4 ticks → outputs 0, `remain` frozen; after the door closes, WASH resumes with 5 s left.
- `start` while `door_open`=1, or with `mode`=0 → stays in IDLE, `busy`=0.
- Assert `reset` mid-RINSE → all outputs 0 immediately (asynchronous). Later `start` → the program restarts from the first phase.
- `tick` and `door_open` in the same cycle during FILL → PAUSE entered, phase timer unchanged.

Source files
------------

// File: rtl/washer_pkg.sv
// washer_pkg: phase codes, default phase durations and mode bit positions shared by wash_sequencer.
package washer_pkg;
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_FILL,
        PH_WASH,
        PH_RINSE,
        PH_DRAIN,
        PH_SPIN,
        PH_PAUSE,
        PH_DONE
    } phase_t;

    localparam int DEF_FILL_S  = 2;
    localparam int DEF_WASH_S  = 9;
    localparam int DEF_RINSE_S = 6;
    localparam int DEF_DRAIN_S = 2;
    localparam int DEF_SPIN_S  = 3;
    localparam int DEF_BEEP_S  = 3;

    localparam int MODE_WASH  = 2;
    localparam int MODE_RINSE = 1;
    localparam int MODE_DRY   = 0;

    function automatic int worst_case_secs(input int fill_s, input int wash_s, input int rinse_s,
                                           input int drain_s, input int spin_s);
        return fill_s + wash_s + 3 * (fill_s + rinse_s + drain_s) + 2 * drain_s + spin_s;
    endfunction
endpackage

// File: rtl/wash_sequencer_sec_timer.sv
// sec_timer: loadable 8-bit seconds down-counter; counts on tick unless held and stops at zero.
module sec_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_tick,
    input  logic       i_hold,
    output logic [7:0] o_count,
    output logic       o_zero
);
    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_count <= 8'd0;
        else if (i_load)
            r_count <= i_load_val;
        else if (i_tick && !i_hold && r_count != 8'd0)
            r_count <= r_count - 8'd1;

    assign o_count = r_count;
    assign o_zero  = r_count == 8'd0;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: steps fill/wash/rinse/drain/spin on a 1 Hz tick with door pause and a program countdown.
// Define WASHER_BEEP_EN to include the end-of-program beep timer; otherwise beep is tied low.
module wash_sequencer
    import washer_pkg::*;
#(
    parameter int FILL_S  = DEF_FILL_S,
    parameter int WASH_S  = DEF_WASH_S,
    parameter int RINSE_S = DEF_RINSE_S,
    parameter int DRAIN_S = DEF_DRAIN_S,
    parameter int SPIN_S  = DEF_SPIN_S,
    parameter int BEEP_S  = DEF_BEEP_S
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       door_open,
    input  logic [2:0] mode,
    input  logic [1:0] rinse_cnt,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       in_water,
    output logic       motor,
    output logic       out_water,
    output logic       spin,
    output logic       busy,
    output logic       done,
    output logic       beep
);
    if (worst_case_secs(FILL_S, WASH_S, RINSE_S, DRAIN_S, SPIN_S) > 255 || BEEP_S > 255) begin : g_width_check
        $fatal(1, "wash_sequencer: program length does not fit the 8-bit counters");
    end

    phase_t     r_state, r_saved, w_state_n, w_saved_n, w_next;
    logic [2:0] r_mode, w_mode_n;
    logic       r_in_rinse, w_in_rinse_n;
    logic [1:0] r_rinse_left, w_rinse_left_n, w_reps;
    logic [7:0] r_remain, w_remain_n, w_total, w_load_val, w_tmr_count;
    logic       w_run, w_start_ok, w_adv, w_term, w_more, w_load, w_tmr_zero;

    function automatic logic [7:0] dur(input phase_t p);
        return p == PH_FILL  ? 8'(FILL_S)  :
               p == PH_WASH  ? 8'(WASH_S)  :
               p == PH_RINSE ? 8'(RINSE_S) :
               p == PH_DRAIN ? 8'(DRAIN_S) :
               p == PH_SPIN  ? 8'(SPIN_S)  : 8'd0;
    endfunction

    always_comb begin
        w_run      = r_state inside {PH_FILL, PH_WASH, PH_RINSE, PH_DRAIN, PH_SPIN};
        w_start_ok = (r_state == PH_IDLE || r_state == PH_DONE) && start && mode != 3'd0 && !door_open;
        w_adv      = w_run && !door_open && tick;
        // A running phase parked at zero (zero-length parameter) still leaves on the next tick.
        w_term     = w_adv && (w_tmr_count == 8'd1 || w_tmr_zero);
        w_reps     = rinse_cnt == 2'd0 ? 2'd1 : rinse_cnt;
        w_total    = (mode[MODE_WASH] ? 8'(FILL_S + WASH_S + DRAIN_S) : 8'd0)
                   + (mode[MODE_RINSE] ? 8'(FILL_S + RINSE_S + DRAIN_S) * {6'd0, w_reps} : 8'd0)
                   + (mode[MODE_DRY] ? 8'(SPIN_S) : 8'd0);
        w_more     = r_in_rinse ? r_rinse_left > 2'd1 : r_mode[MODE_RINSE];
        w_next     = r_state == PH_FILL ? (r_in_rinse ? PH_RINSE : PH_WASH) :
                     (r_state == PH_WASH || r_state == PH_RINSE) ? PH_DRAIN :
                     (r_state == PH_DRAIN && w_more) ? PH_FILL :
                     (r_state == PH_DRAIN && r_mode[MODE_DRY]) ? PH_SPIN : PH_DONE;
        w_state_n      = r_state;
        w_saved_n      = r_saved;
        w_mode_n       = r_mode;
        w_in_rinse_n   = r_in_rinse;
        w_rinse_left_n = r_rinse_left;
        w_remain_n     = (w_adv && r_remain != 8'd0) ? r_remain - 8'd1 : r_remain;
        if (w_start_ok) begin
            w_state_n      = (mode[MODE_WASH] || mode[MODE_RINSE]) ? PH_FILL : PH_SPIN;
            w_mode_n       = mode;
            w_in_rinse_n   = !mode[MODE_WASH];
            w_rinse_left_n = w_reps;
            w_remain_n     = w_total;
        end else if (w_run && door_open) begin
            w_state_n = PH_PAUSE;
            w_saved_n = r_state;
        end else if (w_term) begin
            w_state_n = w_next;
            if (r_state == PH_DRAIN && w_next == PH_FILL) begin
                w_in_rinse_n   = 1'b1;
                w_rinse_left_n = r_in_rinse ? r_rinse_left - 2'd1 : r_rinse_left;
            end
        end else if (r_state == PH_PAUSE && !door_open) begin
            w_state_n = r_saved;
        end
        w_load     = w_start_ok || w_term;
        w_load_val = dur(w_state_n);
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state      <= PH_IDLE;
            r_saved      <= PH_IDLE;
            r_mode       <= 3'd0;
            r_in_rinse   <= 1'b0;
            r_rinse_left <= 2'd0;
            r_remain     <= 8'd0;
        end else begin
            r_state      <= w_state_n;
            r_saved      <= w_saved_n;
            r_mode       <= w_mode_n;
            r_in_rinse   <= w_in_rinse_n;
            r_rinse_left <= w_rinse_left_n;
            r_remain     <= w_remain_n;
        end

    sec_timer u_phase_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .i_tick    (tick),
        .i_hold    (!w_run || door_open),
        .o_count   (w_tmr_count),
        .o_zero    (w_tmr_zero)
    );

    assign phase     = r_state;
    assign remain    = r_remain;
    assign in_water  = r_state == PH_FILL;
    assign motor     = r_state == PH_WASH || r_state == PH_RINSE;
    assign out_water = r_state == PH_DRAIN || r_state == PH_SPIN;
    assign spin      = r_state == PH_SPIN;
    assign busy      = w_run || r_state == PH_PAUSE;
    assign done      = r_state == PH_DONE;

`ifdef WASHER_BEEP_EN
    logic [7:0] w_beep_count;
    logic       w_beep_zero;

    sec_timer u_beep_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_term && w_next == PH_DONE),
        .i_load_val(8'(BEEP_S)),
        .i_tick    (tick),
        .i_hold    (r_state != PH_DONE),
        .o_count   (w_beep_count),
        .o_zero    (w_beep_zero)
    );

    assign beep = r_state == PH_DONE && !w_beep_zero && w_beep_count != 8'd0;
`else
    assign beep = 1'b0;
`endif
endmodule
